// File: rtl/ring_osc_ctrl.sv
// Ring-oscillator sequencer and frequency counter: enable, settle, count edges over a gate window, report.
// Optional stuck-oscillator detection is built when RO_STUCK_EN is defined.
module ring_osc_ctrl #(
  parameter int SETTLE_CYC = 8,
  parameter int GATE_CYC   = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             ro_out,
  output logic             ro_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             stuck
);

  localparam int TMAX  = (SETTLE_CYC > GATE_CYC) ? SETTLE_CYC : GATE_CYC;
  localparam int TMR_W = (TMAX < 2) ? 1 : $clog2(TMAX + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] meas_total;
  logic             ro_en_nxt;
  logic             meas_start, meas_end;
  logic             ro_sync_p0, ro_sync_p1, ro_sync_p2;
  logic             rise;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != {CNT_W{1'b1}}))
      return v + CNT_W'(1);
    return v;
  endfunction

  assign rise       = ro_sync_p1 & ~ro_sync_p2;
  assign meas_total = sat_inc(edge_cnt, rise);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  always_comb begin
    state_nxt  = state;
    tmr_nxt    = '0;
    meas_start = 1'b0;
    meas_end   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort)
          state_nxt = SETTLE;
      end
      SETTLE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (tmr == TMR_W'(SETTLE_CYC - 1)) begin
          state_nxt  = MEASURE;
          meas_start = 1'b1;
        end else begin
          tmr_nxt = tmr + TMR_W'(1);
        end
      end
      MEASURE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (tmr == TMR_W'(GATE_CYC - 1)) begin
          state_nxt = DONE;
          meas_end  = 1'b1;
        end else begin
          tmr_nxt = tmr + TMR_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    ro_en_nxt = (state_nxt == SETTLE) || (state_nxt == MEASURE);
  end

  // Stage p0..p2: two-flop synchronizer plus one edge-detect flop on the async oscillator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tmr        <= '0;
      ro_en      <= 1'b0;
      ro_sync_p0 <= 1'b0;
      ro_sync_p1 <= 1'b0;
      ro_sync_p2 <= 1'b0;
      edge_cnt   <= '0;
      count      <= '0;
    end else begin
      state      <= state_nxt;
      tmr        <= tmr_nxt;
      ro_en      <= ro_en_nxt;
      ro_sync_p0 <= ro_out;
      ro_sync_p1 <= ro_sync_p0;
      ro_sync_p2 <= ro_sync_p1;
      if (meas_start)
        edge_cnt <= '0;
      else if (state == MEASURE)
        edge_cnt <= meas_total;
      // The edge seen on the final gate cycle is folded into the reported result.
      if (meas_end)
        count <= meas_total;
    end
  end

`ifdef RO_STUCK_EN
  logic stuck_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stuck_q <= 1'b0;
    else if (meas_end)
      stuck_q <= (meas_total == '0);
  end

  assign stuck = stuck_q;
`else
  assign stuck = 1'b0;
`endif

endmodule

// File: tb/tb_ring_osc_ctrl.sv
// Randomized self-checking bench for ring_osc_ctrl against a sampled-waveform edge-count model.
module tb_ring_osc_ctrl;
  localparam int S  = 4;
  localparam int G  = 16;
  localparam int W  = 16;
  localparam int W2 = 3;
  localparam int DEPTH = 8192;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          ro_out = 1'b0;
  logic          ro_en, busy, done, stuck;
  logic [W-1:0]  count;

  logic          start2 = 1'b0;
  logic          abort2 = 1'b0;
  logic          ro_out2 = 1'b0;
  logic          ro_en2, busy2, done2, stuck2;
  logic [W2-1:0] count2;

  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   mode = 3;
  int   ph = 0;
  logic samp [0:DEPTH-1];

  ring_osc_ctrl #(.SETTLE_CYC(S), .GATE_CYC(G), .CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ro_out(ro_out),
    .ro_en(ro_en), .busy(busy), .done(done), .count(count), .stuck(stuck)
  );

  ring_osc_ctrl #(.SETTLE_CYC(S), .GATE_CYC(G), .CNT_W(W2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .ro_out(ro_out2),
    .ro_en(ro_en2), .busy(busy2), .done(done2), .count(count2), .stuck(stuck2)
  );

  always #5 clk = ~clk;

  // samp[k] is the oscillator level seen at rising clock edge k.
  always @(posedge clk) begin
    samp[cyc % DEPTH] <= ro_out;
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    ro_out2 = ~ro_out2;
    case (mode)
      0: ro_out = 1'b0;
      1: if (ro_en) begin
           ph = ph + 1;
           if (ph % 2 == 0) ro_out = ~ro_out;
         end
      2: ro_out = 1'(($urandom % 2));
      default: ro_out = ~ro_out;
    endcase
  end

  // Rising transitions of the sampled oscillator stream that land, after the two
  // synchronizer stages, inside the gate window; saturated to the counter width.
  function automatic int model_count(input int n, input int w);
    int c = 0;
    int lim = (1 << w) - 1;
    for (int j = n + S - 1; j <= n + S + G - 2; j++)
      if (samp[j % DEPTH] === 1'b1 && samp[(j - 1) % DEPTH] === 1'b0) c++;
    if (c > lim) c = lim;
    return c;
  endfunction

  function automatic logic model_stuck(input int m);
`ifdef RO_STUCK_EN
    return (m == 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic run_meas(input string tag, output int m);
    int   n;
    bit   got;
    logic [W-1:0] exp_c;
    @(negedge clk);
    start = 1'b1;
    n = cyc;
    @(negedge clk);
    start = 1'b0;
    n_total++;
    if (ro_en !== 1'b1) $display("FAIL %s ro_en_rise: got %b expected 1", tag, ro_en);
    else n_pass++;
    n_total++;
    if (busy !== 1'b1) $display("FAIL %s busy_high: got %b expected 1", tag, busy);
    else n_pass++;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (done === 1'b1) got = 1;
      else @(negedge clk);
    end
    n_total++;
    if (!got) $display("FAIL %s done_timeout: got no done expected done", tag);
    else n_pass++;
    n_total++;
    if ((cyc - 1) != n + S + G) $display("FAIL %s done_cycle: got %0d expected %0d", tag, cyc - 1 - n, S + G);
    else n_pass++;
    n_total++;
    if (ro_en !== 1'b0) $display("FAIL %s ro_en_at_done: got %b expected 0", tag, ro_en);
    else n_pass++;
    m = model_count(n, W);
    exp_c = W'(m);
    n_total++;
    if (count !== exp_c) $display("FAIL %s count: got %0d expected %0d", tag, count, exp_c);
    else n_pass++;
    n_total++;
    if (stuck !== model_stuck(m)) $display("FAIL %s stuck: got %b expected %b", tag, stuck, model_stuck(m));
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL %s idle_after_done: got busy=%b done=%b expected busy=0 done=0", tag, busy, done);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    start2 = 1'b1;
    mode = 3;
    repeat (6) begin
      @(negedge clk);
      n_total++;
      if ({ro_en, busy, done, stuck, count, count2} !== '0)
        $display("FAIL reset_outputs: got ro_en=%b busy=%b done=%b stuck=%b count=%0d count2=%0d expected all 0",
                 ro_en, busy, done, stuck, count, count2);
      else n_pass++;
    end
    start = 1'b0;
    start2 = 1'b0;
    rst_n = 1'b1;
    mode = 1;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    int m;
    run_meas("nominal", m);
    n_total++;
    if (count < 3 || count > 5) $display("FAIL nominal_range: got %0d expected 3..5", count);
    else n_pass++;
  endtask

  task automatic test_stuck();
    int m;
    mode = 0;
    ro_out = 1'b0;
    repeat (3) @(negedge clk);
    run_meas("stuck", m);
    n_total++;
    if (count !== '0) $display("FAIL stuck_count: got %0d expected 0", count);
    else n_pass++;
    mode = 1;
    run_meas("unstuck", m);
    n_total++;
    if (stuck !== 1'b0) $display("FAIL stuck_cleared: got %b expected 0", stuck);
    else n_pass++;
  endtask

  task automatic test_abort();
    logic [W-1:0] prev_c;
    logic         prev_s;
    bit           saw;
    prev_c = count;
    prev_s = stuck;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_total++;
    if (busy !== 1'b1 || ro_en !== 1'b1) $display("FAIL abort_busy_mid: got busy=%b ro_en=%b expected 1 1", busy, ro_en);
    else n_pass++;
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_total++;
    if (busy !== 1'b0 || ro_en !== 1'b0) $display("FAIL abort_idle: got busy=%b ro_en=%b expected 0 0", busy, ro_en);
    else n_pass++;
    saw = 0;
    repeat (30) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) saw = 1;
    end
    n_total++;
    if (saw) $display("FAIL abort_no_done: got activity after abort expected none");
    else n_pass++;
    n_total++;
    if (count !== prev_c || stuck !== prev_s)
      $display("FAIL abort_hold: got count=%0d stuck=%b expected %0d %b", count, stuck, prev_c, prev_s);
    else n_pass++;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    n_total++;
    if (busy !== 1'b0 || ro_en !== 1'b0) $display("FAIL start_abort_idle: got busy=%b ro_en=%b expected 0 0", busy, ro_en);
    else n_pass++;
  endtask

  task automatic test_saturation();
    bit got;
    int n;
    @(negedge clk);
    start2 = 1'b1;
    n = cyc;
    @(negedge clk);
    start2 = 1'b0;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (done2 === 1'b1) got = 1;
      else @(negedge clk);
    end
    n_total++;
    if (!got || (cyc - 1) != n + S + G) $display("FAIL sat_done: got done=%b at %0d expected at %0d", got, cyc - 1 - n, S + G);
    else n_pass++;
    n_total++;
    if (count2 !== 3'd7) $display("FAIL sat_count: got %0d expected 7", count2);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int m;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (S + 3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (ro_en !== 1'b0 || busy !== 1'b0 || count !== '0 || done !== 1'b0)
      $display("FAIL async_reset: got ro_en=%b busy=%b count=%0d done=%b expected 0 0 0 0", ro_en, busy, count, done);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    run_meas("post_reset", m);
  endtask

  task automatic test_random();
    int m;
    mode = 2;
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_meas("random", m);
    end
    mode = 1;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stuck();
    test_abort();
    test_saturation();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
